mtrx_loader: RTL and testbench
==============================

// Module: mtrx_loader
// PURPOSE
//   Serial-to-packed matrix writer feeding the MTRX_Multiplier operand buses (a/b).
//   Accepts matrix elements one per handshake in row-major order over a valid/ready stream.
//   Assembles them into a DIM*DIM*WIDTH packed matrix, optionally transposed.
//   Presents the matrix with matrix_valid and holds it until the consumer acknowledges it.
// PARAMETERS
//   DIM    5  matrix dimension (DIM x DIM); index counter is $clog2(DIM*DIM) bits
//   WIDTH  8  element width in bits; packed bus is DIM*DIM*WIDTH (200 at defaults)
// PORTS
//   clock         in   1          single clock; all state changes on rising edge
//   reset         in   1          asynchronous, active-low reset
//   start         in   1          begin a new load (sampled only in IDLE)
//   transpose     in   1          latched on accepted start; 1 = store element (r,c) at (c,r)
//   abort         in   1          synchronous abandon of any load/hold -> IDLE
//   in_valid      in   1          in_data holds a valid element
//   in_ready      out  1          loader can accept an element this cycle
//   in_data       in   WIDTH      element value, row-major stream order
//   matrix        out  DIM*DIM*WIDTH  packed matrix; element (r,c) at [(r*DIM+c)*WIDTH +: WIDTH]
//   matrix_valid  out  1          matrix complete and stable
//   matrix_ack    in   1          consumer has taken matrix (meaningful only while matrix_valid)
//   count         out  $clog2(DIM*DIM+1)  elements accepted in current load
// BEHAVIOUR
//   Reset (reset low, async): state=IDLE, matrix=0, count=0, in_ready=0, matrix_valid=0, transpose latch=0.
//   States: IDLE, LOAD, FULL. in_ready=1 only in LOAD; matrix_valid=1 only in FULL (registered state decode).
//   IDLE: start=1 -> LOAD next edge; same edge clears matrix to 0, count to 0, latches transpose.
//   LOAD: transfer = in_valid & in_ready at a rising edge. Stream index k=count; r=k/DIM, c=k%DIM.
//     transpose=0 writes in_data to slot r*DIM+c; transpose=1 writes to slot c*DIM+r. count increments.
//     The transfer with k=DIM*DIM-1 moves to FULL on the same edge; count reads DIM*DIM in FULL.
//     matrix_valid is high the cycle after the final transfer; latency final-beat -> valid = 1 clock.
//     in_valid low: no write, no count change. start in LOAD is ignored.
//   FULL: matrix and count held stable; in_ready=0, so in_valid is ignored.
//     matrix_ack=1 -> IDLE next edge; matrix keeps its value in IDLE until the next start.
//     start in FULL is ignored; an ack is required first.
//   abort=1 (any state) -> IDLE next edge, count=0, matrix unchanged; abort beats start/ack/transfer.
//   Simultaneous start and abort in IDLE: abort wins, stay IDLE.
//   matrix_ack outside FULL: ignored.
//   Reset mid-LOAD or mid-FULL: immediate return to reset values; partial data discarded.
//   Elements are stored verbatim (no width change); count never wraps past DIM*DIM.
// TESTING
//   T1 reset low mid-run -> matrix=0, count=0, in_ready=0, matrix_valid=0 asynchronously.
//   T2 start, transpose=0, stream 1,2,...,25 back-to-back -> valid 1 clk after beat 25;
//      element(0,0)=1, (0,4)=5, (4,4)=25; count=25.
//   T3 same stream with transpose=1 -> (0,1)=6, (1,0)=2, (4,0)=5; diagonal unchanged.
//   T4 in_valid toggled every other cycle with alternating 1/2 pattern -> 25 writes only;
//      hold 3 clks with ack=0 (matrix stable, in_ready=0, extra in_valid ignored); ack -> IDLE.
//   T5 abort after 10 beats -> IDLE, count=0; new start clears matrix; full 25-beat load succeeds.
//   T6 feed loaded operands (all-ones B, alternating 1/2 A) to MTRX_Multiplier mode 0 -> rows 7/8/7/8/7.

Source files
------------

// File: rtl/mtrx_loader_if.sv
// Stream-in / matrix-out bundle between mtrx_loader and its producer and consumer.
// The loader attaches to the slave modport; the driving side uses master.
interface mtrx_loader_if #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8
);
  logic                          start;
  logic                          transpose;
  logic                          abort;
  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              in_data;
  logic [DIM*DIM*WIDTH-1:0]      matrix;
  logic                          matrix_valid;
  logic                          matrix_ack;
  logic [$clog2(DIM*DIM+1)-1:0]  count;

  modport slave (
    input  start, transpose, abort, in_valid, in_data, matrix_ack,
    output in_ready, matrix, matrix_valid, count
  );

  modport master (
    output start, transpose, abort, in_valid, in_data, matrix_ack,
    input  in_ready, matrix, matrix_valid, count
  );
endinterface

// File: rtl/mtrx_loader.sv
// Collects DIM*DIM elements from a valid/ready stream into a packed matrix
// (optionally transposed) and holds it until the consumer acknowledges it.
module mtrx_loader #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  mtrx_loader_if.slave  bus
);
  localparam int N     = DIM * DIM;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   count_r;
  logic [IDX_W-1:0]   row_r;
  logic [IDX_W-1:0]   col_r;
  logic [IDX_W-1:0]   slot_s;
  logic               transpose_r;
  logic               in_ready_r;
  logic               matrix_valid_r;
  logic [N*WIDTH-1:0] matrix_r;
  logic               xfer_s;

  // Destination slot of the current beat; row/col counters avoid a divider.
  always_comb begin
    xfer_s = bus.in_valid & in_ready_r;
    if (transpose_r) begin
      slot_s = IDX_W'(int'(col_r) * DIM + int'(row_r));
    end else begin
      slot_s = IDX_W'(int'(row_r) * DIM + int'(col_r));
    end
  end

  // Control FSM with registered handshake flags and matrix storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      count_r        <= '0;
      row_r          <= '0;
      col_r          <= '0;
      transpose_r    <= 1'b0;
      in_ready_r     <= 1'b0;
      matrix_valid_r <= 1'b0;
      matrix_r       <= '0;
    end else if (bus.abort) begin
      // Abort keeps whatever partial matrix was written.
      state_r        <= IDLE;
      count_r        <= '0;
      row_r          <= '0;
      col_r          <= '0;
      in_ready_r     <= 1'b0;
      matrix_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r        <= LOAD;
            count_r        <= '0;
            row_r          <= '0;
            col_r          <= '0;
            transpose_r    <= bus.transpose;
            matrix_r       <= '0;
            in_ready_r     <= 1'b1;
            matrix_valid_r <= 1'b0;
          end else begin
            in_ready_r     <= 1'b0;
            matrix_valid_r <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer_s) begin
            matrix_r[int'(slot_s)*WIDTH +: WIDTH] <= bus.in_data;
            count_r <= count_r + CNT_W'(1);
            if (col_r == IDX_W'(DIM - 1)) begin
              col_r <= '0;
              row_r <= row_r + IDX_W'(1);
            end else begin
              col_r <= col_r + IDX_W'(1);
            end
            if (count_r == CNT_W'(N - 1)) begin
              state_r        <= FULL;
              in_ready_r     <= 1'b0;
              matrix_valid_r <= 1'b1;
            end else begin
              in_ready_r     <= 1'b1;
              matrix_valid_r <= 1'b0;
            end
          end else begin
            in_ready_r     <= 1'b1;
            matrix_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (bus.matrix_ack) begin
            state_r        <= IDLE;
            matrix_valid_r <= 1'b0;
          end else begin
            matrix_valid_r <= 1'b1;
          end
          in_ready_r <= 1'b0;
        end
        default: begin
          state_r        <= IDLE;
          count_r        <= '0;
          row_r          <= '0;
          col_r          <= '0;
          in_ready_r     <= 1'b0;
          matrix_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.matrix_valid = matrix_valid_r;
  assign bus.matrix       = matrix_r;
  assign bus.count        = count_r;
endmodule

// File: tb/tb_mtrx_loader.sv
// Directed bench for mtrx_loader: inputs change on the falling edge and
// outputs are checked on the falling edge after each rising edge.
module tb_mtrx_loader;
  localparam int DIM   = 5;
  localparam int WIDTH = 8;
  localparam int MW    = DIM * DIM * WIDTH;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [MW-1:0] exp_m;
  logic [MW-1:0] held_m;

  mtrx_loader_if #(.DIM(DIM), .WIDTH(WIDTH)) bus ();

  mtrx_loader #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [WIDTH-1:0] elem(input int r, input int c);
    logic [MW-1:0] m;
    m = bus.matrix;
    return m[(r*DIM+c)*WIDTH +: WIDTH];
  endfunction

  // Ramp 1..25 in row-major stream order, placed transposed when tr is set.
  function automatic logic [MW-1:0] ramp(input bit tr);
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        if (tr) m[(c*DIM+r)*WIDTH +: WIDTH] = WIDTH'(r*DIM + c + 1);
        else    m[(r*DIM+c)*WIDTH +: WIDTH] = WIDTH'(r*DIM + c + 1);
      end
    end
    return m;
  endfunction

  task automatic do_start(input logic tr);
    bus.start = 1'b1;
    bus.transpose = tr;
    tick();
    bus.start = 1'b0;
    bus.transpose = 1'b0;
  endtask

  task automatic beats(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(first + i);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.transpose = 1'b0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.matrix_ack = 1'b0;
    @(negedge clock);
    chk("rst_matrix", 256'(bus.matrix), 256'(0));
    chk("rst_count", 256'(bus.count), 256'(0));
    chk("rst_in_ready", 256'(bus.in_ready), 256'(0));
    chk("rst_valid", 256'(bus.matrix_valid), 256'(0));
    tick();
    reset = 1'b1;
    tick();

    // T2: plain row-major load
    do_start(1'b0);
    chk("t2_ready", 256'(bus.in_ready), 256'(1));
    chk("t2_count0", 256'(bus.count), 256'(0));
    beats(24, 1);
    chk("t2_valid_early", 256'(bus.matrix_valid), 256'(0));
    chk("t2_count24", 256'(bus.count), 256'(24));
    beats(1, 25);
    chk("t2_valid", 256'(bus.matrix_valid), 256'(1));
    chk("t2_ready_full", 256'(bus.in_ready), 256'(0));
    chk("t2_count", 256'(bus.count), 256'(25));
    chk("t2_e00", 256'(elem(0, 0)), 256'(1));
    chk("t2_e04", 256'(elem(0, 4)), 256'(5));
    chk("t2_e44", 256'(elem(4, 4)), 256'(25));
    exp_m = ramp(1'b0);
    chk("t2_matrix", 256'(bus.matrix), 256'(exp_m));
    bus.matrix_ack = 1'b1;
    tick();
    bus.matrix_ack = 1'b0;
    chk("t2_ack_valid", 256'(bus.matrix_valid), 256'(0));
    chk("t2_idle_keep", 256'(bus.matrix), 256'(exp_m));
    bus.matrix_ack = 1'b1;
    tick();
    bus.matrix_ack = 1'b0;
    chk("ack_in_idle", 256'(bus.in_ready), 256'(0));

    // T3: transposed load
    do_start(1'b1);
    beats(25, 1);
    chk("t3_valid", 256'(bus.matrix_valid), 256'(1));
    chk("t3_e01", 256'(elem(0, 1)), 256'(6));
    chk("t3_e10", 256'(elem(1, 0)), 256'(2));
    chk("t3_e40", 256'(elem(4, 0)), 256'(5));
    chk("t3_e22", 256'(elem(2, 2)), 256'(13));
    exp_m = ramp(1'b1);
    chk("t3_matrix", 256'(bus.matrix), 256'(exp_m));
    bus.matrix_ack = 1'b1;
    tick();
    bus.matrix_ack = 1'b0;

    // start together with abort in IDLE: stays idle
    bus.abort = 1'b1;
    do_start(1'b0);
    bus.abort = 1'b0;
    chk("start_abort_idle", 256'(bus.in_ready), 256'(0));

    // T4: gapped stream of 1/2 values; idle cycles carry junk that must not land
    do_start(1'b0);
    for (int k = 0; k < 25; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (k % 2 == 0) ? 8'd1 : 8'd2;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hEE;
      if (k == 9) chk("t4_count10", 256'(bus.count), 256'(10));
      if (k < 24) tick();
    end
    chk("t4_valid", 256'(bus.matrix_valid), 256'(1));
    chk("t4_count", 256'(bus.count), 256'(25));
    exp_m = '0;
    for (int k = 0; k < 25; k++) exp_m[k*WIDTH +: WIDTH] = (k % 2 == 0) ? 8'd1 : 8'd2;
    chk("t4_matrix", 256'(bus.matrix), 256'(exp_m));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.start    = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("t4_hold_matrix", 256'(bus.matrix), 256'(exp_m));
      chk("t4_hold_ready", 256'(bus.in_ready), 256'(0));
      chk("t4_hold_valid", 256'(bus.matrix_valid), 256'(1));
      chk("t4_hold_count", 256'(bus.count), 256'(25));
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    // T6: rows times an all-ones B give 7/8/7/8/7
    for (int r = 0; r < DIM; r++) begin
      int s;
      s = 0;
      for (int c = 0; c < DIM; c++) s += int'(elem(r, c));
      chk("t6_rowsum", 256'(s), 256'((r % 2 == 0) ? 7 : 8));
    end
    bus.matrix_ack = 1'b1;
    tick();
    bus.matrix_ack = 1'b0;
    chk("t4_ack_idle", 256'(bus.matrix_valid), 256'(0));

    // T5: abort after 10 beats keeps partial data, then a full reload
    do_start(1'b0);
    beats(10, 100);
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    tick();
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_abort_count", 256'(bus.count), 256'(0));
    chk("t5_abort_ready", 256'(bus.in_ready), 256'(0));
    exp_m = '0;
    for (int k = 0; k < 10; k++) exp_m[k*WIDTH +: WIDTH] = WIDTH'(100 + k);
    chk("t5_abort_matrix", 256'(bus.matrix), 256'(exp_m));
    do_start(1'b0);
    chk("t5_clear", 256'(bus.matrix), 256'(0));
    beats(25, 1);
    exp_m = ramp(1'b0);
    chk("t5_reload", 256'(bus.matrix), 256'(exp_m));
    chk("t5_valid", 256'(bus.matrix_valid), 256'(1));
    // abort out of FULL
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_full_valid", 256'(bus.matrix_valid), 256'(0));
    chk("abort_full_count", 256'(bus.count), 256'(0));

    // T1: asynchronous reset mid-load
    do_start(1'b0);
    beats(5, 40);
    held_m = bus.matrix;
    chk("t1_partial", 256'(held_m[4*WIDTH +: WIDTH]), 256'(44));
    #2;
    reset = 1'b0;
    #1;
    chk("t1_matrix", 256'(bus.matrix), 256'(0));
    chk("t1_count", 256'(bus.count), 256'(0));
    chk("t1_ready", 256'(bus.in_ready), 256'(0));
    chk("t1_valid", 256'(bus.matrix_valid), 256'(0));
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("t1_stay_idle", 256'(bus.in_ready), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
